uart_tx_arbiter: RTL and testbench

- Round-robin scheduler that shares one UART transmitter among NUM_REQ byte sources, typically FIFOs with first-word-fall-through read ports.
- Picks a non-empty requester and latches its head byte into the transmitter data input.
- Pops that FIFO, holds tx_start until the transmitter reports frame completion, then re-arbitrates.
- Sits between the per-channel TX FIFOs and the single uart_tx instance.

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle linking the per-channel TX FIFOs, the round-robin arbiter and the UART transmitter.
// The master modport is the arbiter's view. The slave modport is the view of the surrounding FIFOs and transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int IDX_SIZE  = $clog2(NUM_REQ)
);
  logic                         enable;
  logic [NUM_REQ-1:0]           req_empty;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           rd_en;
  logic                         tx_start;
  logic [DATA_SIZE-1:0]         tx_data;
  logic                         tx_done_tick;
  logic [IDX_SIZE-1:0]          grant_idx;
  logic                         busy;
  logic                         frame_done_tick;
  logic                         timeout_err;

  modport master (
    input  enable, req_empty, req_data, tx_done_tick,
    output rd_en, tx_start, tx_data, grant_idx, busy, frame_done_tick, timeout_err
  );

  modport slave (
    output enable, req_empty, req_data, tx_done_tick,
    input  rd_en, tx_start, tx_data, grant_idx, busy, frame_done_tick, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ FWFT byte FIFOs.
// Optional SEND watchdog: define UART_ARB_TIMEOUT_EN (otherwise timeout_err is tied 0).
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int IDX_SIZE  = $clog2(NUM_REQ),
  parameter int TIMEOUT_W = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01
  } state_e;

  localparam logic [IDX_SIZE-1:0] PTR_RST = IDX_SIZE'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [IDX_SIZE-1:0]  ptr_q, ptr_d;
  logic [IDX_SIZE-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]   rd_en_q, rd_en_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 done_d_q;
  logic                 done_rise;

  logic [NUM_REQ-1:0]   has_data;
  logic [DATA_SIZE-1:0] head [NUM_REQ];
  logic [IDX_SIZE-1:0]  winner;
  logic                 found;
  int                   cand;

`ifdef UART_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 timeout_err_q, timeout_err_d;
`endif

  assign has_data  = ~bus.req_empty;
  assign done_rise = bus.tx_done_tick & ~done_d_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_head
    assign head[i] = bus.req_data[i*DATA_SIZE +: DATA_SIZE];
  end

  // Search starts just after the last winner and wraps, so each requester waits at most NUM_REQ-1 frames
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    cand   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && has_data[cand[IDX_SIZE-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_SIZE-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = tx_start_q;
    busy_d       = busy_q;
    rd_en_d      = '0;
    frame_done_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      IDLE: begin
        tx_start_d = 1'b0;
        busy_d     = 1'b0;
        if (bus.enable && found) begin
          state_d         = SEND;
          ptr_d           = winner;
          grant_d         = winner;
          tx_data_d       = head[winner];
          rd_en_d[winner] = 1'b1;
          tx_start_d      = 1'b1;
          busy_d          = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
          wd_d            = '0;
`endif
        end
      end
      SEND: begin
        // tx_done_tick may be held for several cycles; only its rising edge ends the frame
        if (done_rise) begin
          state_d      = IDLE;
          tx_start_d   = 1'b0;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else begin
          wd_d = wd_q + 1'b1;
          if (&wd_d) begin
            state_d       = IDLE;
            tx_start_d    = 1'b0;
            busy_d        = 1'b0;
            timeout_err_d = 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d    = IDLE;
        tx_start_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= PTR_RST;
      grant_q      <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      rd_en_q      <= '0;
      frame_done_q <= 1'b0;
      done_d_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= busy_d;
      rd_en_q      <= rd_en_d;
      frame_done_q <= frame_done_d;
      done_d_q     <= bus.tx_done_tick;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.rd_en           = rd_en_q;
  assign bus.tx_start        = tx_start_q;
  assign bus.tx_data         = tx_data_q;
  assign bus.grant_idx       = grant_q;
  assign bus.busy            = busy_q;
  assign bus.frame_done_tick = frame_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: FWFT FIFO models, a simple transmitter model and hand-computed expectations.
// Define UART_ARB_TIMEOUT_EN to exercise the watchdog with a 4-bit counter.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int IW = 2;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 20;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_SIZE(DW), .IDX_SIZE(IW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_SIZE(DW), .IDX_SIZE(IW), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // FWFT FIFO models, popped on each rd_en pulse
  logic [7:0] fmem [NR][8];
  int fhead [NR];
  int fcnt  [NR];

  always_comb begin
    bus.req_empty = '1;
    bus.req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      if (fcnt[i] > 0) begin
        bus.req_empty[i]          = 1'b0;
        bus.req_data[i*DW +: DW]  = fmem[i][fhead[i]];
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (bus.rd_en[i] === 1'b1) begin
          fhead[i]++;
          fcnt[i]--;
        end
      end
    end
  end

  task automatic push(input int r, input logic [7:0] b);
    fmem[r][fhead[r] + fcnt[r]] = b;
    fcnt[r]++;
  endtask

  task automatic fifo_clear();
    for (int i = 0; i < NR; i++) begin
      fhead[i] = 0;
      fcnt[i]  = 0;
    end
  endtask

  // Transmitter model: samples tx_start only when idle, then raises done for 5 cycles
  logic       model_on;
  logic [7:0] rx_byte  [16];
  int         rx_grant [16];
  int         rx_n;

  initial begin
    bus.tx_done_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (model_on && bus.tx_start === 1'b1) begin
        if (rx_n < 16) begin
          rx_byte[rx_n]  = bus.tx_data;
          rx_grant[rx_n] = int'(bus.grant_idx);
        end
        rx_n++;
        repeat (3) @(posedge clk);
        #1 bus.tx_done_tick = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.tx_done_tick = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    fifo_clear();
    rx_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (bus.tx_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_eq({tag, "_start"}, 32'(bus.tx_start), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.frame_done_tick !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_eq({tag, "_done"}, 32'(bus.frame_done_tick), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_watchdog: observed no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int fd, hi, bad;
    logic [7:0] eb;

    reset_n    = 1'b0;
    bus.enable = 1'b1;
    model_on   = 1'b0;
    rx_n       = 0;
    fifo_clear();

    // Reset state and 100 idle cycles with nothing to send
    repeat (3) @(negedge clk);
    check_eq("rst_hold", 32'({bus.tx_start, bus.busy, bus.rd_en, bus.grant_idx,
                              bus.frame_done_tick, bus.timeout_err, bus.tx_data}), 32'd0);
    reset_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      check_eq("rst_idle", 32'({bus.tx_start, bus.busy, bus.rd_en, bus.grant_idx,
                                bus.frame_done_tick, bus.timeout_err}), 32'd0);
    end

    // Single requester 2
    model_on = 1'b1;
    @(negedge clk);
    push(2, 8'hA5);
    tick();
    check_eq("single_start", 32'(bus.tx_start), 32'd1);
    check_eq("single_data",  32'(bus.tx_data), 32'hA5);
    check_eq("single_rden",  32'(bus.rd_en), 32'b0100);
    check_eq("single_gidx",  32'(bus.grant_idx), 32'd2);
    check_eq("single_busy",  32'(bus.busy), 32'd1);
    tick();
    check_eq("single_rden_off", 32'(bus.rd_en), 32'd0);
    check_eq("single_hold", 32'({bus.tx_start, bus.tx_data}), 32'h1A5);
    fd = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.frame_done_tick === 1'b1) fd++;
    end
    check_eq("single_fdone_cnt", 32'(fd), 32'd1);
    check_eq("single_idle", 32'({bus.tx_start, bus.busy}), 32'd0);
    check_eq("single_rx_n", 32'(rx_n), 32'd1);
    check_eq("single_rx_byte", 32'(rx_byte[0]), 32'hA5);

    // Round robin over four loaded FIFOs
    do_reset();
    for (int i = 0; i < NR; i++) push(i, 8'(8'h10 + i));
    for (int i = 0; i < NR; i++) push(i, 8'(8'h20 + i));
    for (int c = 0; c < 400 && rx_n < 8; c++) tick();
    check_eq("rr_count", 32'(rx_n), 32'd8);
    for (int k = 0; k < 8; k++) begin
      eb = (k < 4) ? 8'h10 : 8'h20;
      check_eq($sformatf("rr_byte%0d", k), 32'(rx_byte[k]), 32'(eb + 8'(k % 4)));
      check_eq($sformatf("rr_grant%0d", k), 32'(rx_grant[k]), 32'(k % 4));
    end
    tick(15);
    check_eq("rr_drained", 32'({bus.busy, bus.req_empty}), 32'b01111);

    // Enable gating during a requester-1 frame
    do_reset();
    push(1, 8'h31);
    wait_start("gate");
    check_eq("gate_gidx", 32'(bus.grant_idx), 32'd1);
    @(negedge clk);
    bus.enable = 1'b0;
    push(2, 8'h42);
    push(0, 8'h40);
    wait_done("gate");
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.rd_en !== 4'b0000 || bus.tx_start !== 1'b0) bad++;
    end
    check_eq("gate_no_grant", 32'(bad), 32'd0);
    check_eq("gate_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.enable = 1'b1;
    wait_start("gate_resume");
    check_eq("gate_resume_gidx", 32'(bus.grant_idx), 32'd2);
    check_eq("gate_resume_data", 32'(bus.tx_data), 32'h42);
    wait_done("gate_resume");
    wait_start("gate_next");
    check_eq("gate_next_gidx", 32'(bus.grant_idx), 32'd0);
    check_eq("gate_next_data", 32'(bus.tx_data), 32'h40);
    wait_done("gate_next");

    // Reset pulse in the middle of a frame
    tick(15);
    do_reset();
    model_on = 1'b0;
    push(2, 8'h77);
    wait_start("mrst");
    check_eq("mrst_busy", 32'(bus.busy), 32'd1);
    tick(2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mrst_async", 32'({bus.tx_start, bus.busy, bus.rd_en, bus.grant_idx}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    push(0, 8'h80);
    push(3, 8'h83);
    model_on = 1'b1;
    wait_start("mrst_after");
    check_eq("mrst_after_gidx", 32'(bus.grant_idx), 32'd0);
    check_eq("mrst_after_data", 32'(bus.tx_data), 32'h80);
    wait_done("mrst_after");
    wait_start("mrst_next");
    check_eq("mrst_next_gidx", 32'(bus.grant_idx), 32'd3);
    check_eq("mrst_next_data", 32'(bus.tx_data), 32'h83);
    wait_done("mrst_next");
    tick(15);

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog: no done ever arrives
    do_reset();
    model_on = 1'b0;
    push(1, 8'h91);
    push(2, 8'h92);
    wait_start("wd");
    hi = 1;
    fd = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.frame_done_tick === 1'b1) fd++;
      if (bus.tx_start !== 1'b1) break;
      hi++;
    end
    check_eq("wd_send_cycles", 32'(hi), 32'd15);
    check_eq("wd_err", 32'(bus.timeout_err), 32'd1);
    check_eq("wd_no_fdone", 32'(fd), 32'd0);
    check_eq("wd_busy", 32'(bus.busy), 32'd0);
    wait_start("wd_next");
    check_eq("wd_next_gidx", 32'(bus.grant_idx), 32'd2);
    tick(30);
    check_eq("wd_sticky", 32'(bus.timeout_err), 32'd1);
`else
    // Without the watchdog SEND waits indefinitely
    do_reset();
    model_on = 1'b0;
    push(1, 8'h91);
    wait_start("nowd");
    tick(60);
    check_eq("nowd_hold", 32'({bus.tx_start, bus.busy, bus.timeout_err}), 32'b110);
    check_eq("nowd_data", 32'(bus.tx_data), 32'h91);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
